// File: rtl/complex_matrix_row_server.sv
// ---------------------------------------------------------------------------
// complex_matrix_row_server
//
// Purpose: buffers one SIZE x SIZE matrix of complex doubles. Elements arrive
// one at a time in row-major order. Once the last element is stored, the
// matrix is held read-only and whole rows are served with a fixed one-cycle
// latency. With LOWER_MASK set, above-diagonal elements of a served row read
// as zero; the stored data itself is never masked.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   ld_elem_i           complex element {imag[127:64], real[63:0]}
//   ld_valid_i          load element valid
//   ld_ready_o          load element accepted when high with ld_valid_i
//   rd_addr_i           requested row index
//   rd_addr_valid_i     row request valid (level)
//   rd_row_o            served row, element j at [j*128 +: 128]
//   rd_row_addr_o       row index carried by rd_row_o
//   rd_row_valid_o      rd_row_o / rd_row_addr_o valid this cycle
//   release_i           matrix consumed, return to EMPTY (only honoured in FULL)
//   flush_i             abort in any state, discard contents
//   full_o              matrix complete and serving
//   busy_o              state is not EMPTY
// ---------------------------------------------------------------------------

// Lower-triangle mask for one element lane of a served row.
module complex_matrix_row_server_lane #(
    parameter int AW         = 4,
    parameter int LANE       = 0,
    parameter bit LOWER_MASK = 1'b1
) (
    input  logic [127:0]  elem_i,
    input  logic [AW-1:0] row_i,
    output logic [127:0]  elem_o
);
    localparam logic [AW-1:0] LANE_IDX = AW'(LANE);

    assign elem_o = (LOWER_MASK && (LANE_IDX > row_i)) ? '0 : elem_i;
endmodule

module complex_matrix_row_server #(
    parameter int SIZE       = 16,
    parameter bit LOWER_MASK = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [127:0]              ld_elem_i,
    input  logic                      ld_valid_i,
    output logic                      ld_ready_o,
    input  logic [$clog2(SIZE)-1:0]   rd_addr_i,
    input  logic                      rd_addr_valid_i,
    output logic [SIZE*128-1:0]       rd_row_o,
    output logic [$clog2(SIZE)-1:0]   rd_row_addr_o,
    output logic                      rd_row_valid_o,
    input  logic                      release_i,
    input  logic                      flush_i,
    output logic                      full_o,
    output logic                      busy_o
);
    localparam int AW = $clog2(SIZE);
    localparam int EW = 128;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [AW-1:0]              ld_row_q, ld_row_d;
    logic [AW-1:0]              ld_col_q, ld_col_d;
    logic [SIZE*EW-1:0]         rd_row_q, rd_row_d;
    logic [AW-1:0]              rd_row_addr_q, rd_row_addr_d;
    logic                       rd_row_valid_q, rd_row_valid_d;

    // Element storage is deliberately not reset; an incomplete matrix is
    // never served, so stale contents are never visible.
    logic [SIZE-1:0][EW-1:0]    mem_q [SIZE];

    logic [SIZE-1:0][EW-1:0]    row_sel;
    logic [SIZE-1:0][EW-1:0]    row_masked;
    logic                       ld_accept;
    logic                       store_en;
    logic                       last_elem;
    logic                       rd_fire;

    // ld_ready_o is gated by rst_i so it drops asynchronously with reset.
    assign ld_ready_o = ~rst_i & (state_q != ST_FULL);
    assign ld_accept  = ld_valid_i & ld_ready_o;
    // flush wins over a same-cycle element even though ready may be high.
    assign store_en   = ld_accept & ~flush_i;
    assign last_elem  = (ld_row_q == '1) && (ld_col_q == '1);

    // ------------------------------------------------------------------
    // State and load counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ld_row_d = ld_row_q;
        ld_col_d = ld_col_q;
        rd_fire  = 1'b0;
        if (flush_i) begin
            state_d  = ST_EMPTY;
            ld_row_d = '0;
            ld_col_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY, ST_LOAD: begin
                    if (store_en) begin
                        // SIZE is a power of two, so the counters wrap to
                        // 0 by themselves on the last element and then hold
                        // there through FULL.
                        ld_col_d = ld_col_q + 1'b1;
                        if (ld_col_q == '1) begin
                            ld_row_d = ld_row_q + 1'b1;
                        end
                        state_d = last_elem ? ST_FULL : ST_LOAD;
                    end
                end
                ST_FULL: begin
                    if (release_i) begin
                        state_d = ST_EMPTY;
                    end else begin
                        rd_fire = rd_addr_valid_i;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    ld_row_d = '0;
                    ld_col_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path: select the row, mask per lane, register for 1-cycle latency
    // ------------------------------------------------------------------
    assign row_sel = mem_q[rd_addr_i];

    for (genvar j = 0; j < SIZE; j++) begin : g_lane
        complex_matrix_row_server_lane #(
            .AW         (AW),
            .LANE       (j),
            .LOWER_MASK (LOWER_MASK)
        ) u_lane (
            .elem_i (row_sel[j]),
            .row_i  (rd_addr_i),
            .elem_o (row_masked[j])
        );
    end

    always_comb begin
        rd_row_valid_d = rd_fire;
        rd_row_d       = rd_row_q;
        rd_row_addr_d  = rd_row_addr_q;
        if (rd_fire) begin
            rd_row_d      = row_masked;
            rd_row_addr_d = rd_addr_i;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_EMPTY;
            ld_row_q       <= '0;
            ld_col_q       <= '0;
            rd_row_q       <= '0;
            rd_row_addr_q  <= '0;
            rd_row_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ld_row_q       <= ld_row_d;
            ld_col_q       <= ld_col_d;
            rd_row_q       <= rd_row_d;
            rd_row_addr_q  <= rd_row_addr_d;
            rd_row_valid_q <= rd_row_valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store_en) begin
            mem_q[ld_row_q][ld_col_q] <= ld_elem_i;
        end
    end

    assign rd_row_o       = rd_row_q;
    assign rd_row_addr_o  = rd_row_addr_q;
    assign rd_row_valid_o = rd_row_valid_q;
    assign full_o         = (state_q == ST_FULL);
    assign busy_o         = (state_q != ST_EMPTY);
endmodule
